systolic_ctrl: RTL and testbench

- Sequencer for one weight-stationary systolic array of N rows × K columns running a single GEMM tile: Y[M×K] = X[M×N] · W[N×K].
- Loads W from a weight memory and holds it stable for the array.
- Resets the array, then streams M X-rows from an input memory.
- Writes the M Y-rows the array produces to an output memory, with a start/busy/done handshake toward the host.

---
 rtl/sa_ctrl_pkg.sv | 24 ++
 rtl/systolic_ctrl_if.sv | 56 +++++
 rtl/sa_wbuf.sv | 35 +++
 rtl/systolic_ctrl.sv | 130 +++++++++++++
 tb/tb_systolic_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sa_ctrl_pkg.sv
// Shared types and defaults for the systolic array tile sequencer.
package sa_ctrl_pkg;

  localparam int DEF_M  = 5;
  localparam int DEF_N  = 3;
  localparam int DEF_K  = 4;
  localparam int DEF_DW = 32;
  localparam int DEF_AW = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    ARRAY_RST,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  // One spare bit so counters can hold max(M,K) itself.
  function automatic int cnt_width(input int m, input int k);
    return $clog2((m > k) ? m : k) + 1;
  endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Host, memory and array signals of one systolic tile sequencer.
interface systolic_ctrl_if
  import sa_ctrl_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int K          = DEF_K,
  parameter int DATA_WIDTH = DEF_DW,
  parameter int ADDR_WIDTH = DEF_AW
);

  logic                         start;
  logic [ADDR_WIDTH-1:0]        x_base;
  logic [ADDR_WIDTH-1:0]        w_base;
  logic [ADDR_WIDTH-1:0]        y_base;
  logic                         busy;
  logic                         done;
  logic                         err;
  logic                         w_rd_en;
  logic [ADDR_WIDTH-1:0]        w_rd_addr;
  logic [DATA_WIDTH*N-1:0]      w_rd_data;
  logic                         x_rd_en;
  logic [ADDR_WIDTH-1:0]        x_rd_addr;
  logic [DATA_WIDTH*N-1:0]      x_rd_data;
  logic                         y_wr_en;
  logic [ADDR_WIDTH-1:0]        y_wr_addr;
  logic [DATA_WIDTH*K-1:0]      y_wr_data;
  logic                         sa_rst;
  logic [DATA_WIDTH*N-1:0]      sa_x;
  logic [DATA_WIDTH*N*K-1:0]    sa_w;
  logic [DATA_WIDTH*K-1:0]      sa_y;
  logic                         sa_valid;
  logic                         sa_done;

  modport master (
    input  start, x_base, w_base, y_base,
    input  w_rd_data, x_rd_data,
    input  sa_y, sa_valid, sa_done,
    output busy, done, err,
    output w_rd_en, w_rd_addr,
    output x_rd_en, x_rd_addr,
    output y_wr_en, y_wr_addr, y_wr_data,
    output sa_rst, sa_x, sa_w
  );

  modport slave (
    output start, x_base, w_base, y_base,
    output w_rd_data, x_rd_data,
    output sa_y, sa_valid, sa_done,
    input  busy, done, err,
    input  w_rd_en, w_rd_addr,
    input  x_rd_en, x_rd_addr,
    input  y_wr_en, y_wr_addr, y_wr_data,
    input  sa_rst, sa_x, sa_w
  );

endinterface

// File: rtl/sa_wbuf.sv
// Column-addressed weight register file feeding the array.
module sa_wbuf
  import sa_ctrl_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int K  = DEF_K,
  parameter int DW = DEF_DW,
  parameter int IW = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IW-1:0]         idx,
  input  logic [DW*N-1:0]       wdata,
  output logic [DW*N*K-1:0]     sa_w
);

  logic [DW*N-1:0] col [K];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < K; j++)
        col[j] <= '0;
    end else if (we) begin
      for (int j = 0; j < K; j++)
        if (idx == IW'(j))
          col[j] <= wdata;
    end
  end

  for (genvar j = 0; j < K; j++) begin : g_col
    assign sa_w[j*DW*N +: DW*N] = col[j];
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Weight-stationary tile sequencer: load W, reset array, stream X, collect Y.
module systolic_ctrl
  import sa_ctrl_pkg::*;
#(
  parameter int M          = DEF_M,
  parameter int N          = DEF_N,
  parameter int K          = DEF_K,
  parameter int DATA_WIDTH = DEF_DW,
  parameter int ADDR_WIDTH = DEF_AW
) (
  input  logic            clk,
  input  logic            rst,
  systolic_ctrl_if.master bus
);

  localparam int CW = cnt_width(M, K);
  localparam logic [CW-1:0] MC = CW'(M);
  localparam logic [CW-1:0] KC = CW'(K);

  state_t state, state_n;

  logic [CW-1:0]         w_cnt, x_cnt, y_cnt, w_idx;
  logic [ADDR_WIDTH-1:0] xb, wb, yb;
  logic                  x_pend, err_q;
  logic                  start_ok, set_err;
  logic                  w_rd, x_rd, wb_we, y_cap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      w_cnt  <= '0;
      x_cnt  <= '0;
      y_cnt  <= '0;
      x_pend <= 1'b0;
      err_q  <= 1'b0;
      xb     <= '0;
      wb     <= '0;
      yb     <= '0;
    end else begin
      state  <= state_n;
      x_pend <= x_rd;
      if (start_ok) begin
        xb    <= bus.x_base;
        wb    <= bus.w_base;
        yb    <= bus.y_base;
        err_q <= 1'b0;
        w_cnt <= '0;
        x_cnt <= '0;
        y_cnt <= '0;
      end
      if (state == LOAD_W) w_cnt <= w_cnt + CW'(1);
      if (x_rd)            x_cnt <= x_cnt + CW'(1);
      if (y_cap)           y_cnt <= y_cnt + CW'(1);
      if (set_err)         err_q <= 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    start_ok = 1'b0;
    set_err  = 1'b0;
    w_rd     = 1'b0;
    x_rd     = 1'b0;
    wb_we    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          start_ok = 1'b1;
          state_n  = LOAD_W;
        end
      end
      LOAD_W: begin
        // Capture trails the read by one cycle.
        w_rd  = (w_cnt < KC);
        wb_we = (w_cnt != '0);
        if (w_cnt == KC) state_n = ARRAY_RST;
      end
      ARRAY_RST: begin
        x_rd    = 1'b1;
        state_n = STREAM;
      end
      STREAM: begin
        x_rd = (x_cnt < MC);
        if (x_cnt == MC) state_n = DRAIN;
      end
      DRAIN: begin
        if (y_cnt == MC) begin
          state_n = DONE;
        end else if (bus.sa_done) begin
          set_err = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign y_cap = !rst && bus.sa_valid && (y_cnt < MC)
              && (state inside {STREAM, DRAIN, DONE});
  assign w_idx = w_cnt - CW'(1);

  assign bus.busy      = !rst && (state != IDLE);
  assign bus.done      = !rst && (state == DONE);
  assign bus.err       = err_q;
  assign bus.w_rd_en   = !rst && w_rd;
  assign bus.w_rd_addr = wb + ADDR_WIDTH'(w_cnt);
  assign bus.x_rd_en   = !rst && x_rd;
  assign bus.x_rd_addr = xb + ADDR_WIDTH'(x_cnt);
  assign bus.y_wr_en   = y_cap;
  assign bus.y_wr_addr = yb + ADDR_WIDTH'(y_cnt);
  assign bus.y_wr_data = bus.sa_y;
  assign bus.sa_rst    = rst || (state == ARRAY_RST);
  assign bus.sa_x      = (!rst && x_pend) ? bus.x_rd_data : '0;

  sa_wbuf #(
    .N  (N),
    .K  (K),
    .DW (DATA_WIDTH),
    .IW (CW)
  ) u_wbuf (
    .clk   (clk),
    .rst   (rst),
    .we    (!rst && wb_we),
    .idx   (w_idx),
    .wdata (bus.w_rd_data),
    .sa_w  (bus.sa_w)
  );

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed and randomized tiles against a GEMM reference and array model.
module tb_systolic_ctrl;
  import sa_ctrl_pkg::*;

  localparam int M   = DEF_M;
  localparam int N   = DEF_N;
  localparam int K   = DEF_K;
  localparam int DW  = DEF_DW;
  localparam int AW  = DEF_AW;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_ctrl_if #(.N(N), .K(K), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  systolic_ctrl #(
    .M(M), .N(N), .K(K), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Matrices: xm[r][i] = X[r][i], wm[i][j] = W[i][j]
  logic [DW-1:0] xm [M][N];
  logic [DW-1:0] wm [N][K];

  logic [DW*N-1:0] xmem [logic [AW-1:0]];
  logic [DW*N-1:0] wmem [logic [AW-1:0]];

  always @(posedge clk) begin
    if (bus.w_rd_en)
      bus.w_rd_data <= wmem.exists(bus.w_rd_addr) ? wmem[bus.w_rd_addr] : '0;
    if (bus.x_rd_en)
      bus.x_rd_data <= xmem.exists(bus.x_rd_addr) ? xmem[bus.x_rd_addr] : '0;
  end

  // Behavioural array: M rows after its reset, fixed latency, then sa_done.
  typedef struct {
    logic [DW*K-1:0] y;
    int              t;
  } ent_t;
  ent_t aq[$];
  int   a_cyc = 0, a_rows = 0, a_emit = 0, a_extra = 0;
  bit   a_dsent = 0, a_act = 0;
  int   a_lim = M;
  int   a_extra_cfg = 0;

  function automatic logic [DW*K-1:0] arr_mul(input logic [DW*N-1:0] x,
                                              input logic [DW*N*K-1:0] w);
    logic [DW*K-1:0] y;
    logic [DW-1:0]   acc;
    for (int j = 0; j < K; j++) begin
      acc = '0;
      for (int i = 0; i < N; i++)
        acc = acc + x[i*DW +: DW] * w[(j*N+i)*DW +: DW];
      y[j*DW +: DW] = acc;
    end
    return y;
  endfunction

  always @(posedge clk) begin
    a_cyc++;
    bus.sa_valid <= 1'b0;
    bus.sa_done  <= 1'b0;
    if (bus.sa_rst) begin
      aq.delete();
      a_rows  = 0;
      a_emit  = 0;
      a_extra = a_extra_cfg;
      a_dsent = 0;
      a_act   = !rst;
    end else if (a_act) begin
      if (a_rows < M) begin
        aq.push_back('{y: arr_mul(bus.sa_x, bus.sa_w), t: a_cyc + LAT});
        a_rows++;
      end
      if (aq.size() > 0 && aq[0].t <= a_cyc && a_emit < a_lim) begin
        bus.sa_valid <= 1'b1;
        bus.sa_y     <= aq[0].y;
        void'(aq.pop_front());
        a_emit++;
      end else if (a_emit == a_lim && a_extra > 0) begin
        bus.sa_valid <= 1'b1;
        bus.sa_y     <= {$urandom, $urandom, $urandom, $urandom};
        a_extra--;
      end else if (a_emit == a_lim && !a_dsent) begin
        bus.sa_done <= 1'b1;
        a_dsent = 1;
        a_act   = 0;
      end
    end
  end

  logic [AW-1:0]   wa[$];
  logic [DW*K-1:0] wd[$];
  int              n_done = 0;

  always @(posedge clk) begin
    if (bus.y_wr_en) begin
      wa.push_back(bus.y_wr_addr);
      wd.push_back(bus.y_wr_data);
    end
    if (bus.done) n_done++;
  end

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [DW*K-1:0] ref_row(input int r);
    logic [DW*K-1:0] y;
    logic [DW-1:0]   acc;
    for (int j = 0; j < K; j++) begin
      acc = '0;
      for (int i = 0; i < N; i++)
        acc = acc + xm[r][i] * wm[i][j];
      y[j*DW +: DW] = acc;
    end
    return y;
  endfunction

  task automatic load_mem(input logic [AW-1:0] xb, input logic [AW-1:0] wb);
    logic [DW*N-1:0] v;
    logic [AW-1:0]   a;
    for (int r = 0; r < M; r++) begin
      for (int i = 0; i < N; i++) v[i*DW +: DW] = xm[r][i];
      a = xb + AW'(r);
      xmem[a] = v;
    end
    for (int j = 0; j < K; j++) begin
      for (int i = 0; i < N; i++) v[i*DW +: DW] = wm[i][j];
      a = wb + AW'(j);
      wmem[a] = v;
    end
  endtask

  task automatic rand_data();
    for (int r = 0; r < M; r++)
      for (int i = 0; i < N; i++) xm[r][i] = $urandom;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < K; j++) wm[i][j] = $urandom;
  endtask

  task automatic start_tile(input logic [AW-1:0] xb, input logic [AW-1:0] wb,
                            input logic [AW-1:0] yb);
    bus.x_base = xb;
    bus.w_base = wb;
    bus.y_base = yb;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, output bit gap);
    int n = 0;
    gap = 0;
    while (bus.done !== 1'b1 && n < 400) begin
      if (bus.busy !== 1'b1) gap = 1;
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, bus.done, 1'b1);
    chk({tag, "_busy_at_done"}, bus.busy, 1'b1);
    chk({tag, "_busy_gap"}, gap, 1'b0);
  endtask

  task automatic wait_sarst(input string tag);
    int n = 0;
    while (bus.sa_rst !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_sa_rst_seen"}, bus.sa_rst, 1'b1);
  endtask

  task automatic check_writes(input string tag, input int w0,
                              input logic [AW-1:0] yb, input int nexp);
    logic [AW-1:0] ea;
    for (int r = 0; r < nexp && w0 + r < wa.size(); r++) begin
      ea = yb + AW'(r);
      chk($sformatf("%s_addr%0d", tag, r), wa[w0+r], ea);
      chk($sformatf("%s_data%0d", tag, r), wd[w0+r], ref_row(r));
    end
  endtask

  task automatic run_full(input string tag, input logic [AW-1:0] xb,
                          input logic [AW-1:0] wb, input logic [AW-1:0] yb,
                          input int nexp, input logic eerr);
    int w0, d0;
    bit gap;
    w0 = wa.size();
    d0 = n_done;
    load_mem(xb, wb);
    start_tile(xb, wb, yb);
    chk({tag, "_err_clr"}, bus.err, 1'b0);
    wait_done(tag, gap);
    tick(10);
    chk({tag, "_ndone"}, n_done - d0, 1);
    chk({tag, "_nwr"}, wa.size() - w0, nexp);
    check_writes(tag, w0, yb, nexp);
    chk({tag, "_err"}, bus.err, eerr);
    chk({tag, "_idle"}, bus.busy, 1'b0);
  endtask

  initial begin
    int  w0, d0;
    bit  gap;
    logic [AW-1:0] xb, wb, yb;
    logic [DW*K-1:0] row4;

    bus.start  = 1'b0;
    bus.x_base = '0;
    bus.w_base = '0;
    bus.y_base = '0;

    rst = 1'b1;
    tick(3);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_wen", {bus.w_rd_en, bus.x_rd_en, bus.y_wr_en}, 3'b000);
    chk("rst_sa_rst", bus.sa_rst, 1'b1);
    chk("rst_sa_x", bus.sa_x, '0);
    chk("rst_sa_w", bus.sa_w, '0);
    rst = 1'b0;
    tick(2);
    chk("post_rst_sa_rst", bus.sa_rst, 1'b0);

    // Identity-like W: Y row r = {r+1, r+2, r+3, 0}
    for (int r = 0; r < M; r++)
      for (int i = 0; i < N; i++) xm[r][i] = DW'(r + 1 + i);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < K; j++) wm[i][j] = (i == j) ? 1 : 0;
    w0 = wa.size();
    run_full("ident", 16'h0100, 16'h0200, 16'h0300, M, 1'b0);
    row4 = {32'd0, 32'd7, 32'd6, 32'd5};
    if (wa.size() > w0 + 4) chk("ident_row4_lit", wd[w0+4], row4);

    // All-ones W, one spurious trailing valid from the array
    for (int r = 0; r < M; r++)
      for (int i = 0; i < N; i++) xm[r][i] = DW'((i + 1) * (r + 1));
    for (int i = 0; i < N; i++)
      for (int j = 0; j < K; j++) wm[i][j] = 1;
    a_extra_cfg = 1;
    run_full("ones", 16'h0010, 16'h0020, 16'h0040, M, 1'b0);
    a_extra_cfg = 0;

    // Y address wrap
    rand_data();
    run_full("wrap", 16'h1000, 16'h2000, 16'hFFFE, M, 1'b0);

    for (int t = 0; t < 3; t++) begin
      rand_data();
      xb = AW'($urandom);
      wb = xb + AW'(16'h4000);
      yb = AW'($urandom);
      run_full($sformatf("rnd%0d", t), xb, wb, yb, M, 1'b0);
    end

    // start re-asserted inside STREAM must be ignored
    rand_data();
    load_mem(16'h0500, 16'h0600);
    w0 = wa.size();
    d0 = n_done;
    start_tile(16'h0500, 16'h0600, 16'h0700);
    wait_sarst("poke");
    tick(3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("poke", gap);
    tick(10);
    chk("poke_ndone", n_done - d0, 1);
    chk("poke_nwr", wa.size() - w0, M);
    chk("poke_idle", bus.busy, 1'b0);
    check_writes("poke", w0, 16'h0700, M);

    // Reset in the middle of STREAM
    w0 = wa.size();
    d0 = n_done;
    start_tile(16'h0500, 16'h0600, 16'h0800);
    wait_sarst("mrst");
    tick(2);
    rst = 1'b1;
    #1;
    chk("mrst_sa_rst", bus.sa_rst, 1'b1);
    tick();
    rst = 1'b0;
    chk("mrst_busy", bus.busy, 1'b0);
    tick(30);
    chk("mrst_ndone", n_done - d0, 0);
    chk("mrst_nwr", wa.size() - w0, 0);
    rand_data();
    run_full("after_rst", 16'h0900, 16'h0A00, 16'h0B00, M, 1'b0);

    // Array finishes early: err, done, three writes; next start clears err
    rand_data();
    a_lim = 3;
    run_full("short", 16'h0C00, 16'h0D00, 16'h0E00, 3, 1'b1);
    a_lim = M;
    rand_data();
    run_full("clr", 16'h0C00, 16'h0D00, 16'h0F00, M, 1'b0);

    // start held high across DONE launches a back-to-back tile
    rand_data();
    load_mem(16'h2100, 16'h2200);
    w0 = wa.size();
    d0 = n_done;
    bus.x_base = 16'h2100;
    bus.w_base = 16'h2200;
    bus.y_base = 16'h2300;
    bus.start  = 1'b1;
    tick();
    wait_done("held1", gap);
    tick();
    chk("held_idle", bus.busy, 1'b0);
    tick();
    chk("held_restart", bus.busy, 1'b1);
    bus.start = 1'b0;
    wait_done("held2", gap);
    tick(10);
    chk("held_ndone", n_done - d0, 2);
    chk("held_nwr", wa.size() - w0, 2 * M);
    check_writes("held1", w0, 16'h2300, M);
    check_writes("held2", w0 + M, 16'h2300, M);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
